// File: rtl/gp_ctrl_pkg.sv
// gp_ctrl_pkg: shared opcode, state and A-source encodings for the control unit
package gp_ctrl_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ASEL_ALU = 2'b00;
    localparam logic [1:0] ASEL_IN  = 2'b01;
    localparam logic [1:0] ASEL_RAM = 2'b10;

    // Binary state codes double as the debug State output value
    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_ADD    = 4'd5,
        S_SUB    = 4'd6,
        S_INPUT  = 4'd7,
        S_JZ     = 4'd8,
        S_JPOS   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    // Map an opcode to the execute state that DECODE branches into
    function automatic state_t decode_op(input logic [2:0] op);
        case (op)
            OP_LOAD:  return S_LOAD;
            OP_STORE: return S_STORE;
            OP_ADD:   return S_ADD;
            OP_SUB:   return S_SUB;
            OP_INPUT: return S_INPUT;
            OP_JZ:    return S_JZ;
            OP_JPOS:  return S_JPOS;
            default:  return S_HALT;
        endcase
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect: synchronises an asynchronous key and emits a one-cycle rising-edge pulse
module key_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic Reset,
    input  logic key,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // Shift the key through the synchroniser and remember the last synchronised level
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], key};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and edge flops, cleared asynchronously by the system reset
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/gp_control_unit.sv
// gp_control_unit: fetch/decode/execute FSM driving the 8-bit datapath control lines
module gp_control_unit
    import gp_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit INPUT_WAIT  = 1'b1
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic [2:0] IR,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       Enter,
    output logic       PCload,
    output logic       JMPmux,
    output logic       IRload,
    output logic       Meminst,
    output logic       MemWr,
    output logic       Aload,
    output logic       Sub,
    output logic [1:0] Asel,
    output logic       Halted,
    output logic [3:0] State
);

    state_t state_q, state_d;
    logic   enter_pulse;
    logic   input_go;

    key_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_key (
        .clock(clock),
        .Reset(Reset),
        .key  (Enter),
        .pulse(enter_pulse)
    );

    // An edge arriving outside INPUT simply expires; only INPUT consumes it
    assign input_go = !INPUT_WAIT || enter_pulse;

    // Next-state and Moore control decode; JZ/JPOS PCload follows the stable status flag
    always_comb begin
        state_d = state_q;
        PCload  = 1'b0;
        JMPmux  = 1'b0;
        IRload  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Aload   = 1'b0;
        Sub     = 1'b0;
        Asel    = ASEL_ALU;
        Halted  = 1'b0;
        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                IRload  = 1'b1;
                PCload  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                Meminst = 1'b1;
                state_d = decode_op(IR);
            end
            S_LOAD: begin
                Meminst = 1'b1;
                Asel    = ASEL_RAM;
                Aload   = 1'b1;
                state_d = S_FETCH;
            end
            S_STORE: begin
                Meminst = 1'b1;
                MemWr   = 1'b1;
                state_d = S_FETCH;
            end
            S_ADD: begin
                Meminst = 1'b1;
                Aload   = 1'b1;
                state_d = S_FETCH;
            end
            S_SUB: begin
                Meminst = 1'b1;
                Aload   = 1'b1;
                Sub     = 1'b1;
                state_d = S_FETCH;
            end
            S_INPUT: begin
                Asel    = ASEL_IN;
                Aload   = input_go;
                state_d = input_go ? S_FETCH : S_INPUT;
            end
            S_JZ: begin
                JMPmux  = 1'b1;
                Meminst = 1'b1;
                PCload  = Aeq0;
                state_d = S_FETCH;
            end
            S_JPOS: begin
                JMPmux  = 1'b1;
                Meminst = 1'b1;
                PCload  = Apos;
                state_d = S_FETCH;
            end
            S_HALT: Halted = 1'b1;
            default: state_d = S_INIT;
        endcase
    end

    // State register; reset forces INIT so every control drops at once
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) state_q <= S_INIT;
        else        state_q <= state_d;
    end

    assign State = state_q;

endmodule
